prg_flash_cmd_seq: RTL

PRG_FLASH_CMD_SEQ -- requirements
Module: prg_flash_cmd_seq

---
 rtl/prg_flash_cmd_seq_if.sv | 30 +++
 rtl/prg_flash_cmd_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/prg_flash_cmd_seq_if.sv
// rtl/prg_flash_cmd_seq_if.sv - command handshake and flash bus bundle for prg_flash_cmd_seq
interface prg_flash_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [26:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [26:0] fl_addr;
  logic [7:0]  fl_dout;
  logic [7:0]  fl_din;
  logic        fl_dout_en;
  logic        fl_ce_n;
  logic        fl_oe_n;
  logic        fl_we_n;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, fl_din,
    input  cmd_ready, fl_addr, fl_dout, fl_dout_en, fl_ce_n, fl_oe_n, fl_we_n,
           busy, done, error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, fl_din,
    output cmd_ready, fl_addr, fl_dout, fl_dout_en, fl_ce_n, fl_oe_n, fl_we_n,
           busy, done, error
  );
endinterface

// File: rtl/prg_flash_cmd_seq.sv
// rtl/prg_flash_cmd_seq.sv - AMD-style parallel flash command sequencer with DQ6 toggle polling
module prg_flash_cmd_seq #(
  parameter int unsigned TIMEOUT_W     = 24,
  parameter logic [26:0] AMD_UNLOCK_A1 = 27'h0000AAA
) (
  input logic                m2,
  input logic                rst_n,
  prg_flash_cmd_seq_if.slave bus
);
  localparam logic [26:0] AMD_UNLOCK_A2 = AMD_UNLOCK_A1 >> 1;

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, RD_SETUP, RD_SAMPLE, RECOVER_SETUP, RECOVER_STROBE, FINISH
  } state_t;

  state_t               state, state_nx;
  logic [1:0]           op_q;
  logic [26:0]          addr_q;
  logic [7:0]           data_q;
  logic [2:0]           idx_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 error_q, dq6_q, first_q, retry_q;

  logic [26:0] wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  last_idx;
  logic        accept, tmo_hit, toggled, rd_abort;

  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign tmo_hit  = &tmo_q;
  assign toggled  = bus.fl_din[6] != dq6_q;
  assign rd_abort = (state == RD_SETUP || state == RD_SAMPLE) && (state_nx == RECOVER_SETUP);

  // Address/data pair for the current write index of the latched op
  always_comb begin
    wr_addr  = AMD_UNLOCK_A1;
    wr_data  = 8'hAA;
    last_idx = 3'd5;
    case (op_q)
      2'b00:   last_idx = 3'd3;
      2'b11:   last_idx = 3'd0;
      default: last_idx = 3'd5;
    endcase
    if (op_q == 2'b11) begin
      wr_addr = addr_q;
      wr_data = 8'hF0;
    end else begin
      case (idx_q)
        3'd0: begin wr_addr = AMD_UNLOCK_A1; wr_data = 8'hAA; end
        3'd1: begin wr_addr = AMD_UNLOCK_A2; wr_data = 8'h55; end
        3'd2: begin wr_addr = AMD_UNLOCK_A1; wr_data = (op_q == 2'b00) ? 8'hA0 : 8'h80; end
        3'd3: begin
          wr_addr = (op_q == 2'b00) ? addr_q : AMD_UNLOCK_A1;
          wr_data = (op_q == 2'b00) ? data_q : 8'hAA;
        end
        3'd4: begin wr_addr = AMD_UNLOCK_A2; wr_data = 8'h55; end
        default: begin
          wr_addr = (op_q == 2'b01) ? addr_q : AMD_UNLOCK_A1;
          wr_data = (op_q == 2'b01) ? 8'h30 : 8'h10;
        end
      endcase
    end
  end

  // Next state: write bus cycles, then toggle polling, timeout taking priority
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.cmd_valid) state_nx = WR_SETUP;
      WR_SETUP:  state_nx = WR_STROBE;
      WR_STROBE: begin
        if (idx_q != last_idx)  state_nx = WR_SETUP;
        else if (op_q == 2'b11) state_nx = FINISH;
        else                    state_nx = RD_SETUP;
      end
      RD_SETUP:  state_nx = tmo_hit ? RECOVER_SETUP : RD_SAMPLE;
      RD_SAMPLE: begin
        if (tmo_hit)      state_nx = RECOVER_SETUP;
        else if (first_q) state_nx = RD_SETUP;
        else if (!toggled) state_nx = FINISH;
        else if (retry_q) state_nx = RECOVER_SETUP;
        else              state_nx = RD_SETUP;
      end
      RECOVER_SETUP:  state_nx = RECOVER_STROBE;
      RECOVER_STROBE: state_nx = FINISH;
      FINISH:         state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Command latch, write index, poll bookkeeping and sticky error
  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
      dq6_q   <= 1'b0;
      first_q <= 1'b1;
      retry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.cmd_op;
        addr_q  <= bus.cmd_addr;
        data_q  <= bus.cmd_data;
        idx_q   <= '0;
        tmo_q   <= '0;
        error_q <= 1'b0;
        first_q <= 1'b1;
        retry_q <= 1'b0;
      end
      if (state == WR_STROBE) idx_q <= idx_q + 3'd1;
      if (state == RD_SETUP || state == RD_SAMPLE) tmo_q <= tmo_q + 1'b1;
      if (state == RD_SAMPLE) begin
        dq6_q   <= bus.fl_din[6];
        first_q <= 1'b0;
        // DQ5 on a toggling read grants exactly one more read before giving up
        if (!first_q && toggled && bus.fl_din[5]) retry_q <= 1'b1;
      end
      if (rd_abort) error_q <= 1'b1;
    end
  end

  // Flash strobes and bus drive decoded from state
  always_comb begin
    bus.fl_ce_n    = 1'b1;
    bus.fl_oe_n    = 1'b1;
    bus.fl_we_n    = 1'b1;
    bus.fl_dout_en = 1'b0;
    bus.fl_addr    = '0;
    bus.fl_dout    = '0;
    case (state)
      WR_SETUP, WR_STROBE: begin
        bus.fl_ce_n    = 1'b0;
        bus.fl_we_n    = (state != WR_STROBE);
        bus.fl_dout_en = 1'b1;
        bus.fl_addr    = wr_addr;
        bus.fl_dout    = wr_data;
      end
      RD_SETUP, RD_SAMPLE: begin
        bus.fl_ce_n = 1'b0;
        bus.fl_oe_n = 1'b0;
        bus.fl_addr = addr_q;
      end
      RECOVER_SETUP, RECOVER_STROBE: begin
        bus.fl_ce_n    = 1'b0;
        bus.fl_we_n    = (state != RECOVER_STROBE);
        bus.fl_dout_en = 1'b1;
        bus.fl_addr    = addr_q;
        bus.fl_dout    = 8'hF0;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FINISH);
  assign bus.error     = error_q;
endmodule
